// File: rtl/score_keeper.sv
`default_nettype none
// score_keeper: brick-hit scoring with combo bonus, saturating 4-digit BCD score,
// session high score and seven-segment display select.  Revision 1.0
module score_keeper #(
  parameter int ALT_PERIOD = 32,
  parameter int COMBO_MAX  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  state,
  input  logic [3:0]  collision_trig,
  output logic [15:0] nums,
  output logic [15:0] score_bcd,
  output logic [15:0] high_bcd,
  output logic [2:0]  combo,
  output logic        new_high
);

  localparam int         ALT_W     = $clog2(ALT_PERIOD) + 1;
  localparam logic [2:0] COMBO_CAP = 3'(COMBO_MAX);

  typedef enum logic [1:0] {
    GS_MENU   = 2'd0,
    GS_WIN    = 2'd1,
    GS_LOSE   = 2'd2,
    GS_STAGE1 = 2'd3
  } game_t;

  game_t            cur_st, prev_st;
  logic [3:0]       trig_q, events;
  logic [ALT_W-1:0] alt_cnt, alt_eff;
  logic             is_end_st, game_start, game_end, alt_entry, scoring;
  logic             unused_wall;
  logic [15:0]      score_sum;

  // Decimal-adjusted add of 1..7 into four BCD digits; any carry out of the top digit saturates.
  function automatic logic [15:0] bcd_add(input logic [15:0] a, input logic [2:0] v);
    logic [4:0]  d;
    logic [3:0]  carry;
    logic [15:0] r;
    carry = {1'b0, v};
    r     = '0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, carry};
      if (d > 5'd9) begin
        r[4*i +: 4] = 4'(d - 5'd10);
        carry       = 4'd1;
      end else begin
        r[4*i +: 4] = d[3:0];
        carry       = 4'd0;
      end
    end
    return (carry != 4'd0) ? 16'h9999 : r;
  endfunction

  always_comb begin
    cur_st      = (state <= 3'd3) ? game_t'(state[1:0]) : GS_MENU;
    is_end_st   = (cur_st == GS_WIN) || (cur_st == GS_LOSE);
    game_start  = (prev_st == GS_MENU) && (cur_st == GS_STAGE1);
    game_end    = (prev_st == GS_STAGE1) && is_end_st;
    alt_entry   = is_end_st && (prev_st != cur_st);
    // The entry cycle itself already counts as phase 0 of the alternation.
    alt_eff     = alt_entry ? '0 : alt_cnt;
    scoring     = (cur_st == GS_STAGE1) && !game_start;
    events      = collision_trig & ~trig_q;
    unused_wall = events[0];
    score_sum   = bcd_add(score_bcd, combo);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_q    <= 4'b0000;
      prev_st   <= GS_MENU;
      alt_cnt   <= '0;
      score_bcd <= 16'h0000;
      high_bcd  <= 16'h0000;
      combo     <= 3'd1;
      new_high  <= 1'b0;
      nums      <= 16'h0000;
    end else begin
      trig_q  <= collision_trig;
      prev_st <= cur_st;
      alt_cnt <= is_end_st ? alt_eff + 1'b1 : '0;

      if (game_start) begin
        score_bcd <= 16'h0000;
        combo     <= 3'd1;
        new_high  <= 1'b0;
      end else if (game_end) begin
        // Valid BCD orders the same as plain binary.
        if (score_bcd > high_bcd) begin
          high_bcd <= score_bcd;
          new_high <= 1'b1;
        end else begin
          new_high <= 1'b0;
        end
      end else if (scoring) begin
        if (events[2]) begin
          score_bcd <= score_sum;
          if (combo < COMBO_CAP) combo <= combo + 3'd1;
        end
        if (events[1] || events[3]) combo <= 3'd1;
      end

      case (cur_st)
        GS_MENU:   nums <= high_bcd;
        GS_STAGE1: nums <= score_bcd;
        default:   nums <= alt_eff[ALT_W-1] ? high_bcd : score_bcd;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// tb_score_keeper: table-driven vectors with an expected-value queue, plus
// hand sequences for high score, display alternation, saturation and reset.
module tb_score_keeper;

  localparam int ALT = 32;
  localparam logic [2:0] M = 3'd0, W = 3'd1, L = 3'd2, S = 3'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  state;
  logic [3:0]  collision_trig;
  logic [15:0] nums, score_bcd, high_bcd;
  logic [2:0]  combo;
  logic        new_high;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  score_keeper #(.ALT_PERIOD(ALT), .COMBO_MAX(4)) dut (
    .clk(clk), .rst(rst), .state(state), .collision_trig(collision_trig),
    .nums(nums), .score_bcd(score_bcd), .high_bcd(high_bcd),
    .combo(combo), .new_high(new_high)
  );

  typedef struct {
    logic [2:0]  st;
    logic [3:0]  trig;
    logic [15:0] score;
    logic [2:0]  combo;
  } vec_t;

  typedef struct {
    logic [15:0] score;
    logic [15:0] nums;
    logic [2:0]  combo;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] st, input logic [3:0] trig,
                     input logic [15:0] score, input logic [2:0] cmb);
    vec_t v;
    v.st = st; v.trig = trig; v.score = score; v.combo = cmb;
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic [2:0] st, input logic [3:0] trig);
    @(negedge clk);
    state          = st;
    collision_trig = trig;
    @(posedge clk);
    #1;
  endtask

  task automatic brick();
    cyc(S, 4'b0100);
    cyc(S, 4'b0000);
  endtask

  task automatic disp(input logic [2:0] st, input logic [15:0] a,
                      input logic [15:0] b, input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      sb.push_back('{16'h0, ((c % (2*ALT)) < ALT) ? a : b, 3'd0});
      cyc(st, 4'b0000);
      e = sb.pop_front();
      chk("disp_nums", nums, e.nums);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t        e;
    logic [15:0] prev_score;

    // Combo chain, level hold, simultaneous events, ball-lost and wall bits.
    add(M, 4'b0000, 16'h0000, 3'd1);
    add(S, 4'b0100, 16'h0000, 3'd1);   // brick on the clear cycle is dropped
    add(S, 4'b0000, 16'h0000, 3'd1);
    add(S, 4'b0100, 16'h0001, 3'd2);
    add(S, 4'b0000, 16'h0001, 3'd2);
    add(S, 4'b0100, 16'h0003, 3'd3);
    add(S, 4'b0000, 16'h0003, 3'd3);
    add(S, 4'b0100, 16'h0006, 3'd4);
    add(S, 4'b0000, 16'h0006, 3'd4);
    add(S, 4'b0100, 16'h0010, 3'd4);
    add(S, 4'b0000, 16'h0010, 3'd4);
    add(S, 4'b0100, 16'h0014, 3'd4);
    add(S, 4'b0010, 16'h0014, 3'd1);
    add(S, 4'b0000, 16'h0014, 3'd1);
    add(S, 4'b0100, 16'h0015, 3'd2);
    add(S, 4'b0000, 16'h0015, 3'd2);
    for (int i = 0; i < 10; i++) add(S, 4'b0100, 16'h0017, 3'd3);
    add(S, 4'b0000, 16'h0017, 3'd3);
    add(S, 4'b0110, 16'h0020, 3'd1);
    add(S, 4'b0000, 16'h0020, 3'd1);
    add(S, 4'b0100, 16'h0021, 3'd2);
    add(S, 4'b0000, 16'h0021, 3'd2);
    add(S, 4'b1000, 16'h0021, 3'd1);
    add(S, 4'b0001, 16'h0021, 3'd1);
    add(S, 4'b0000, 16'h0021, 3'd1);

    rst = 1'b1; state = M; collision_trig = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_nums", nums, 16'h0000);
    chk("rst_score", score_bcd, 16'h0000);
    chk("rst_high", high_bcd, 16'h0000);
    chk("rst_combo", 16'(combo), 16'd1);
    chk("rst_new_high", 16'(new_high), 16'd0);

    prev_score = 16'h0000;
    foreach (tbl[i]) begin
      @(negedge clk);
      state          = tbl[i].st;
      collision_trig = tbl[i].trig;
      sb.push_back('{tbl[i].score, prev_score, tbl[i].combo});
      prev_score = tbl[i].score;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("vec_score", score_bcd, e.score);
      chk("vec_nums", nums, e.nums);
      chk("vec_combo", 16'(combo), 16'(e.combo));
    end

    // Game 1: 42 then LOSE, new high.
    cyc(M, 4'b0000);
    cyc(S, 4'b0000);
    chk("g1_clear", score_bcd, 16'h0000);
    repeat (12) brick();
    chk("g1_score", score_bcd, 16'h0042);
    disp(L, 16'h0042, 16'h0042, 64);
    chk("g1_high", high_bcd, 16'h0042);
    chk("g1_new_high", 16'(new_high), 16'd1);

    // Game 2: 17 then WIN, high kept.
    cyc(M, 4'b0000);
    chk("menu_nums", nums, 16'h0042);
    chk("menu_new_high", 16'(new_high), 16'd1);
    cyc(S, 4'b0000);
    chk("g2_clear_new_high", 16'(new_high), 16'd0);
    chk("g2_clear_score", score_bcd, 16'h0000);
    repeat (5) brick();
    chk("g2_score14", score_bcd, 16'h0014);
    cyc(S, 4'b0010);
    cyc(S, 4'b0000);
    chk("g2_paddle_combo", 16'(combo), 16'd1);
    brick();
    brick();
    chk("g2_score", score_bcd, 16'h0017);
    disp(W, 16'h0017, 16'h0042, 70);
    chk("g2_high", high_bcd, 16'h0042);
    chk("g2_new_high", 16'(new_high), 16'd0);
    cyc(M, 4'b0000);
    chk("menu2_nums", nums, 16'h0042);

    // Saturation: 1+2+3 then 2498 bricks at combo 4 lands on 9998.
    cyc(S, 4'b0000);
    repeat (2501) brick();
    chk("sat_9998", score_bcd, 16'h9998);
    chk("sat_combo", 16'(combo), 16'd4);
    brick();
    chk("sat_9999", score_bcd, 16'h9999);
    brick();
    chk("sat_hold", score_bcd, 16'h9999);
    cyc(W, 4'b0000);
    chk("sat_high", high_bcd, 16'h9999);
    chk("sat_new_high", 16'(new_high), 16'd1);

    // Reset mid-game clears the high score too.
    cyc(M, 4'b0000);
    cyc(S, 4'b0000);
    brick();
    chk("g4_score", score_bcd, 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    cyc(S, 4'b0100);
    rst = 1'b0;
    chk("mrst_score", score_bcd, 16'h0000);
    chk("mrst_high", high_bcd, 16'h0000);
    chk("mrst_nums", nums, 16'h0000);
    chk("mrst_combo", 16'(combo), 16'd1);
    chk("mrst_new_high", 16'(new_high), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
